// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory bus between the instruction-fetch port and the data port.
// Data wins arbitration unless fetch has waited through STARVE_LIMIT
// consecutive data grants. Misaligned or illegal requests are answered with an
// error pulse without touching the bus. Bus transfers outstanding for TIMEOUT
// cycles are aborted with an error.
//
// Ports
//   clk, resetn                      clock, synchronous active-low reset
//   if_req/if_addr                   fetch request (level) and address
//   if_rdata/if_ready/if_error       fetched word, completion/error pulses
//   d_read_req/d_write_req           data request (level)
//   d_addr/d_wdata/d_size/d_signed   data address, store data, size, sign flag
//   d_rdata/d_ready/d_error          load data, completion/error pulses
//   d_stall                          combinational stall for the memory stage
//   bus_*                            registered bus request, bus_rdata/ready/error in
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int XLEN         = 64,
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [31:0]     if_rdata,
    output logic            if_ready,
    output logic            if_error,
    input  logic            d_read_req,
    input  logic            d_write_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [2:0]      d_size,
    input  logic            d_signed,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ready,
    output logic            d_error,
    output logic            d_stall,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic            bus_read,
    output logic            bus_write,
    output logic [2:0]      bus_size,
    output logic            bus_signed,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ready,
    input  logic            bus_error
);
    // TIMEOUT-1 fits in clog2(TIMEOUT) bits because TIMEOUT >= 2.
    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

    state_t            r_state,      w_state_next;
    logic              r_grant_d,    w_grant_d_next;   // 1: data owns the transaction
    logic              r_err,        w_err_next;       // response is an error
    logic [TW-1:0]     r_tcnt,       w_tcnt_next;
    logic [SW-1:0]     r_starve,     w_starve_next;
    logic [XLEN-1:0]   r_bus_addr,   w_bus_addr_next;
    logic [XLEN-1:0]   r_bus_wdata,  w_bus_wdata_next;
    logic              r_bus_read,   w_bus_read_next;
    logic              r_bus_write,  w_bus_write_next;
    logic [2:0]        r_bus_size,   w_bus_size_next;
    logic              r_bus_signed, w_bus_signed_next;
    logic [31:0]       r_if_rdata,   w_if_rdata_next;
    logic [XLEN-1:0]   r_d_rdata,    w_d_rdata_next;

    logic w_d_pend, w_pick_d, w_pick_f, w_d_misalign, w_d_illegal, w_f_illegal;
    logic [SW-1:0] w_starve_inc;

    assign w_d_pend = d_read_req | d_write_req;
    // Fetch takes the bus only once data has won STARVE_LIMIT times in a row.
    assign w_pick_d = w_d_pend & ~(if_req & (r_starve == SW'(STARVE_LIMIT)));
    assign w_pick_f = ~w_pick_d & if_req;

    always_comb begin
        w_d_misalign = 1'b0;
        case (d_size[1:0])
            2'd0:    w_d_misalign = 1'b0;
            2'd1:    w_d_misalign = d_addr[0];
            2'd2:    w_d_misalign = |d_addr[1:0];
            default: w_d_misalign = |d_addr[2:0];
        endcase
    end

    assign w_d_illegal  = (d_read_req & d_write_req) | d_size[2] | w_d_misalign;
    assign w_f_illegal  = |if_addr[1:0];
    assign w_starve_inc = (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + SW'(1);

    always_comb begin
        w_state_next      = r_state;
        w_grant_d_next    = r_grant_d;
        w_err_next        = r_err;
        w_tcnt_next       = r_tcnt;
        w_starve_next     = r_starve;
        w_bus_addr_next   = r_bus_addr;
        w_bus_wdata_next  = r_bus_wdata;
        w_bus_read_next   = r_bus_read;
        w_bus_write_next  = r_bus_write;
        w_bus_size_next   = r_bus_size;
        w_bus_signed_next = r_bus_signed;
        w_if_rdata_next   = r_if_rdata;
        w_d_rdata_next    = r_d_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_pick_d) begin
                    w_grant_d_next = 1'b1;
                    w_starve_next  = if_req ? w_starve_inc : '0;
                    if (w_d_illegal) begin
                        w_state_next = S_RESP;
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next      = S_BUSY;
                        w_err_next        = 1'b0;
                        w_tcnt_next       = '0;
                        w_bus_addr_next   = d_addr;
                        w_bus_wdata_next  = d_wdata;
                        w_bus_size_next   = d_size;
                        w_bus_signed_next = d_signed;
                        w_bus_read_next   = d_read_req;
                        w_bus_write_next  = d_write_req;
                    end
                end else if (w_pick_f) begin
                    w_grant_d_next = 1'b0;
                    w_starve_next  = '0;
                    if (w_f_illegal) begin
                        w_state_next = S_RESP;
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next      = S_BUSY;
                        w_err_next        = 1'b0;
                        w_tcnt_next       = '0;
                        w_bus_addr_next   = if_addr;
                        w_bus_wdata_next  = '0;
                        w_bus_size_next   = 3'd2;
                        w_bus_signed_next = 1'b0;
                        w_bus_read_next   = 1'b1;
                        w_bus_write_next  = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                // Error has priority over ready when both arrive together.
                if (bus_error || bus_ready || (r_tcnt == TW'(TIMEOUT - 1))) begin
                    w_state_next     = S_RESP;
                    w_bus_read_next  = 1'b0;
                    w_bus_write_next = 1'b0;
                    w_err_next       = ~(bus_ready & ~bus_error);
                    if (bus_ready && !bus_error) begin
                        if (r_grant_d) w_d_rdata_next  = bus_rdata;
                        else           w_if_rdata_next = bus_rdata[31:0];
                    end
                end else begin
                    w_tcnt_next = r_tcnt + TW'(1);
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_grant_d    <= 1'b0;
            r_err        <= 1'b0;
            r_tcnt       <= '0;
            r_starve     <= '0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_read   <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_size   <= '0;
            r_bus_signed <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant_d    <= w_grant_d_next;
            r_err        <= w_err_next;
            r_tcnt       <= w_tcnt_next;
            r_starve     <= w_starve_next;
            r_bus_addr   <= w_bus_addr_next;
            r_bus_wdata  <= w_bus_wdata_next;
            r_bus_read   <= w_bus_read_next;
            r_bus_write  <= w_bus_write_next;
            r_bus_size   <= w_bus_size_next;
            r_bus_signed <= w_bus_signed_next;
            r_if_rdata   <= w_if_rdata_next;
            r_d_rdata    <= w_d_rdata_next;
        end
    end

    // Response pulses are decoded from the RESP state, so they last one cycle.
    assign if_ready   = (r_state == S_RESP) & ~r_grant_d & ~r_err;
    assign if_error   = (r_state == S_RESP) & ~r_grant_d &  r_err;
    assign d_ready    = (r_state == S_RESP) &  r_grant_d & ~r_err;
    assign d_error    = (r_state == S_RESP) &  r_grant_d &  r_err;
    assign d_stall    = w_d_pend & ~d_ready & ~d_error;
    assign if_rdata   = r_if_rdata;
    assign d_rdata    = r_d_rdata;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_read   = r_bus_read;
    assign bus_write  = r_bus_write;
    assign bus_size   = r_bus_size;
    assign bus_signed = r_bus_signed;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (XLEN=64, TIMEOUT=16, STARVE_LIMIT=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready, if_error;
    logic        d_read_req, d_write_req;
    logic [63:0] d_addr, d_wdata;
    logic [2:0]  d_size;
    logic        d_signed;
    logic [63:0] d_rdata;
    logic        d_ready, d_error, d_stall;
    logic [63:0] bus_addr, bus_wdata;
    logic        bus_read, bus_write;
    logic [2:0]  bus_size;
    logic        bus_signed;
    logic [63:0] bus_rdata;
    logic        bus_ready, bus_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(64), .TIMEOUT(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_error(if_error),
        .d_read_req(d_read_req), .d_write_req(d_write_req),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size), .d_signed(d_signed),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_error(d_error), .d_stall(d_stall),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_size(bus_size), .bus_signed(bus_signed),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_error(bus_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {if_ready, if_error, d_ready, d_error}
    function automatic logic [3:0] pulses();
        return {if_ready, if_error, d_ready, d_error};
    endfunction

    initial begin
        logic [9:0] grant_pat;
        resetn = 1'b0;
        if_req = 1'b1; if_addr = 64'h400;
        d_read_req = 1'b1; d_write_req = 1'b0;
        d_addr = 64'h1000; d_wdata = '0; d_size = 3'd3; d_signed = 1'b0;
        bus_rdata = '0; bus_ready = 1'b0; bus_error = 1'b0;

        // Reset held with requests high.
        step(); step(); step();
        chk("rst_strobes", {62'd0, bus_read, bus_write}, 64'd0);
        chk("rst_pulses", {60'd0, pulses()}, 64'd0);
        chk("rst_bus_addr", bus_addr, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_d_stall", {63'd0, d_stall}, 64'd1);
        $display("TXN reset");

        // Data load, zero-wait memory; data granted first after reset.
        resetn = 1'b1;
        step();
        chk("load_bus_read", {63'd0, bus_read}, 64'd1);
        chk("load_bus_addr", bus_addr, 64'h1000);
        chk("load_bus_size", {61'd0, bus_size}, 64'd3);
        bus_ready = 1'b1; bus_rdata = 64'hDEADBEEF_CAFEF00D;
        step();
        chk("load_pulses", {60'd0, pulses()}, 64'b0010);
        chk("load_d_rdata", d_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("load_d_stall", {63'd0, d_stall}, 64'd0);
        chk("load_strobe_low", {63'd0, bus_read}, 64'd0);
        d_read_req = 1'b0; bus_ready = 1'b0;
        $display("TXN data load");

        // Fetch follows once data is gone.
        step();
        chk("resp_gap_pulses", {60'd0, pulses()}, 64'd0);
        step();
        chk("fetch_bus_read", {63'd0, bus_read}, 64'd1);
        chk("fetch_bus_addr", bus_addr, 64'h400);
        chk("fetch_bus_size", {61'd0, bus_size}, 64'd2);
        bus_ready = 1'b1; bus_rdata = 64'h11111111_00000013;
        step();
        chk("fetch_pulses", {60'd0, pulses()}, 64'b1000);
        chk("fetch_if_rdata", {32'd0, if_rdata}, 64'h13);
        chk("fetch_d_rdata_hold", d_rdata, 64'hDEADBEEF_CAFEF00D);
        if_req = 1'b0; bus_ready = 1'b0;
        step();
        $display("TXN fetch");

        // Starvation: both ports held, zero-wait memory.
        grant_pat = 10'b1111011110;
        d_read_req = 1'b1; d_addr = 64'h2000; d_size = 3'd3;
        if_req = 1'b1; if_addr = 64'h400;
        bus_ready = 1'b1; bus_rdata = 64'hA5A5A5A5_5A5A5A5A;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("starve_grant%0d", i), bus_addr,
                grant_pat[9-i] ? 64'h2000 : 64'h400);
            step();
            chk($sformatf("starve_pulse%0d", i), {60'd0, pulses(), 1'b0, bus_read} >> 0,
                grant_pat[9-i] ? 64'b0010_0_0 : 64'b1000_0_0);
            step();
            $display("TXN starve %0d grant=%s", i, grant_pat[9-i] ? "D" : "F");
        end
        d_read_req = 1'b0; if_req = 1'b0; bus_ready = 1'b0;
        step();

        // Misaligned store and misaligned fetch.
        d_write_req = 1'b1; d_addr = 64'h1002; d_size = 3'd2; d_wdata = 64'h55;
        step();
        chk("mis_d_pulses", {60'd0, pulses()}, 64'b0001);
        chk("mis_d_no_bus", {62'd0, bus_read, bus_write}, 64'd0);
        d_write_req = 1'b0;
        step();
        chk("mis_d_after", {58'd0, pulses(), bus_read, bus_write}, 64'd0);
        if_req = 1'b1; if_addr = 64'h2;
        step();
        chk("mis_f_pulses", {60'd0, pulses()}, 64'b0100);
        chk("mis_f_no_bus", {63'd0, bus_read}, 64'd0);
        if_req = 1'b0;
        step();
        $display("TXN misaligned");

        // Simultaneous bus_ready and bus_error on a signed half load.
        d_read_req = 1'b1; d_addr = 64'h10; d_size = 3'd1; d_signed = 1'b1;
        step();
        chk("berr_strobe", {59'd0, bus_read, bus_size, bus_signed}, {59'd0, 1'b1, 3'd1, 1'b1});
        bus_ready = 1'b1; bus_error = 1'b1; bus_rdata = 64'h5555;
        step();
        chk("berr_pulses", {60'd0, pulses()}, 64'b0001);
        chk("berr_rdata_hold", d_rdata, 64'hA5A5A5A5_5A5A5A5A);
        d_read_req = 1'b0; d_signed = 1'b0; bus_ready = 1'b0; bus_error = 1'b0;
        step();
        $display("TXN bus error");

        // Legal store.
        d_write_req = 1'b1; d_addr = 64'h3008; d_size = 3'd3; d_wdata = 64'h01234567_89ABCDEF;
        step();
        chk("store_strobes", {62'd0, bus_read, bus_write}, 64'b01);
        chk("store_wdata", bus_wdata, 64'h01234567_89ABCDEF);
        bus_ready = 1'b1;
        step();
        chk("store_pulses", {58'd0, pulses(), bus_read, bus_write}, 64'b0010_00);
        d_write_req = 1'b0; bus_ready = 1'b0;
        step();
        $display("TXN store");

        // Fetch timeout: error exactly 16 cycles after strobe rise.
        if_req = 1'b1; if_addr = 64'h800;
        step();
        chk("to_strobe_rise", {63'd0, bus_read}, 64'd1);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("to_wait%0d", k), {62'd0, if_error, bus_read}, 64'b01);
        end
        step();
        chk("to_expire", {62'd0, if_error, bus_read}, 64'b10);
        if_req = 1'b0;
        step();
        $display("TXN timeout");

        // Reset while a transfer is outstanding.
        d_read_req = 1'b1; d_addr = 64'h40; d_size = 3'd3;
        step();
        chk("mid_busy", {63'd0, bus_read}, 64'd1);
        resetn = 1'b0;
        step();
        chk("mid_rst_strobe", {58'd0, pulses(), bus_read, bus_write}, 64'd0);
        chk("mid_rst_rdata", d_rdata, 64'd0);
        step();
        chk("mid_rst_hold", {58'd0, pulses(), bus_read, bus_write}, 64'd0);
        resetn = 1'b1; d_read_req = 1'b0;
        step();
        chk("mid_rst_after", {58'd0, pulses(), bus_read, bus_write}, 64'd0);
        $display("TXN reset mid-transfer");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter for the RISC-V core: shares a single memory bus between the instruction-fetch port and the memory-access stage's data port. Data accesses normally take priority, and a starvation guard guarantees fetch progress. It also rejects misaligned or illegal requests without touching the bus and aborts bus transfers that exceed a timeout. It sits between the pipeline front/memory stages and the memory model/bus fabric.

## Interface
Parameters:
- XLEN, 9'd64, data/address width.
- TIMEOUT, 16, max cycles a bus transfer may stay outstanding (≥2).
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- if_req  in  1  fetch read request, level, held until if_ready/if_error.
- if_addr  in  XLEN  fetch address.
- if_rdata  out  32  fetched instruction (bus_rdata[31:0]).
- if_ready  out  1  one-cycle completion pulse, fetch.
- if_error  out  1  one-cycle error pulse, fetch.
- d_read_req, d_write_req  in  1 each  data request, level, held until d_ready/d_error.
- d_addr, d_wdata  in  XLEN  data address / store data.
- d_size  in  3  0=byte,1=half,2=word,3=double.
- d_signed  in  1  load sign-extend flag, passed through.
- d_rdata  out  XLEN  load data.
- d_ready, d_error  out  1  one-cycle completion / error pulses, data.
- d_stall  out  1  combinational: (d_read_req|d_write_req) & ~d_ready & ~d_error.
- bus_addr, bus_wdata  out  XLEN  registered bus address / store data.
- bus_read, bus_write  out  1  registered bus strobes, held until bus_ready/bus_error.
- bus_size  out  3; bus_signed  out  1  registered, fetch drives size=2, signed=0.
- bus_rdata  in  XLEN; bus_ready  in  1; bus_error  in  1.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: samples requests. Pending-data = d_read_req|d_write_req.
  - Grant data if pending-data and not (if_req and starve_cnt==STARVE_LIMIT); else grant fetch if if_req.
  - Illegal check at grant: data with both read and write, d_size>3, or d_addr not aligned to 1<<d_size; fetch with if_addr[1:0]!=0. Illegal → RESP with error, no bus strobe.
  - Legal → load bus_* registers, assert bus_read or bus_write, go BUSY, clear timeout counter.
- BUSY: hold all bus_* stable. bus_ready → capture bus_rdata, go RESP with success. bus_error → go RESP with error. Timeout counter reaches TIMEOUT-1 without either → abort, go RESP with error. bus_ready and bus_error together → error wins.
- RESP: drop bus strobes; pulse ready or error to granted requester only; go IDLE. Requests ignored in RESP.
- starve_cnt: increments (saturating at STARVE_LIMIT) on each data grant while if_req high; cleared on any fetch grant or data grant with if_req low.
- if_rdata/d_rdata update only on successful completion of that port; hold otherwise.
- Reset (any state): state IDLE, all outputs 0 (d_stall follows inputs), counters 0; an in-flight transfer is dropped with no response pulse.

## Timing
- Request sampled in IDLE at cycle N → bus strobe high at N+1.
- bus_ready/bus_error sampled at cycle M → strobe low and requester pulse at M+1, IDLE at M+2.
- Zero-wait memory (bus_ready at N+1) → completion pulse at N+2; throughput 1 transfer per 3 cycles.
- Illegal request at N → error pulse at N+1, no bus activity.
- Timeout: strobe asserted N+1, error pulse at N+1+TIMEOUT, strobe low same cycle.
- Requester drops request the cycle after seeing its pulse; still-high request at IDLE is a new transaction.
- Bus strobe deasserted at least one cycle between transfers.

## Test plan
- Reset: hold resetn=0 with all requests high 3 cycles → all outputs 0, no strobes; release → data granted first.
- Data load d_addr=0x1000, size=3, bus_ready at N+1 with bus_rdata=0xDEADBEEF_CAFEF00D → bus_read N+1, d_ready pulse N+2 with d_rdata equal, d_stall low at N+2.
- Starvation: data and fetch held continuously, STARVE_LIMIT=4 → grant order D,D,D,D,F,D,D,D,D,F.
- Misaligned: d_write_req, d_addr=0x1002, size=2 → d_error pulse next cycle, bus_write never asserted; fetch if_addr=0x2 → if_error.
- Timeout: fetch granted, bus_ready never asserted, TIMEOUT=16 → if_error exactly 16 cycles after strobe rise, strobe low same cycle.
- Reset mid-transfer: resetn=0 while BUSY → strobe low next cycle, no ready/error pulse.
